// File: rtl/snail_pkg.sv
// Shared definitions for the snail serializer and the pattern detector bench:
// state encoding, counter sizing and default word geometry.
package snail_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int SNAIL_WIDTH = 8;
    localparam int SNAIL_GAP   = 0;
    localparam int GAP_CNT_W   = 8;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/snail_hold_buf.sv
// One-entry valid/ready holding register in front of the serializer shift register.
// Ready is withheld whenever the entry is occupied, even on the edge it drains.
module snail_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             din_valid_i,
    output logic             din_ready_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign din_ready_o = ~full_q & ~rst_i;
    assign data_o      = data_q;
    assign full_o      = full_q;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (din_valid_i && din_ready_o) begin
            full_d = 1'b1;
            data_d = din_i;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/snail_bit_serializer.sv
// Parallel-to-serial front end for the snail detector: one bit per clock,
// zeros while idle and during the optional inter-word gap.
module snail_bit_serializer
    import snail_pkg::*;
#(
    parameter int WIDTH     = SNAIL_WIDTH,
    parameter int GAP       = SNAIL_GAP,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_active,
    output logic             word_done
);

    localparam int                   CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]        BIT_LAST = CW'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);
    localparam int                   OUT_IDX  = MSB_FIRST ? WIDTH - 1 : 0;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     shreg_q, shreg_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic                 load;
    logic                 buf_full;
    logic [WIDTH-1:0]     buf_data;

    snail_hold_buf #(.WIDTH(WIDTH)) u_hold_buf (
        .clk_i       (clk),
        .rst_i       (rst),
        .din_i       (din),
        .din_valid_i (din_valid),
        .din_ready_o (din_ready),
        .pop_i       (load),
        .data_o      (buf_data),
        .full_o      (buf_full)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        load      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (buf_full) load = 1'b1;
            end
            ST_SHIFT: begin
                shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                if (bit_cnt_q == BIT_LAST) begin
                    if (GAP > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end else if (buf_full) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (buf_full) load = 1'b1;
                    else          state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A reload from any state restarts the word with a fresh bit counter.
        if (load) begin
            state_d   = ST_SHIFT;
            shreg_d   = buf_data;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign dout        = (state_q == ST_SHIFT) & shreg_q[OUT_IDX];
    assign dout_active = (state_q == ST_SHIFT);
    assign word_done   = (state_q == ST_SHIFT) & (bit_cnt_q == BIT_LAST);

endmodule

// File: tb/tb_snail_bit_serializer.sv
// Directed bench for snail_bit_serializer: three instances cover GAP=0 MSB-first,
// GAP=2 MSB-first and GAP=0 LSB-first.
module tb_snail_bit_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] din_w [3];
    logic [2:0] valid_w;
    logic [2:0] ready_w;
    logic [2:0] dout_w;
    logic [2:0] act_w;
    logic [2:0] done_w;

    int passed = 0;
    int total  = 0;

    snail_bit_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .din(din_w[0]), .din_valid(valid_w[0]), .din_ready(ready_w[0]),
        .dout(dout_w[0]), .dout_active(act_w[0]), .word_done(done_w[0]));

    snail_bit_serializer #(.WIDTH(8), .GAP(2), .MSB_FIRST(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .din(din_w[1]), .din_valid(valid_w[1]), .din_ready(ready_w[1]),
        .dout(dout_w[1]), .dout_active(act_w[1]), .word_done(done_w[1]));

    snail_bit_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b0)) u_dut2 (
        .clk(clk), .rst(rst), .din(din_w[2]), .din_valid(valid_w[2]), .din_ready(ready_w[2]),
        .dout(dout_w[2]), .dout_active(act_w[2]), .word_done(done_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Samples n cycles of instance k; bit i of each vector is the expectation for
    // the i-th sample. valid is dropped after the first edge of the stream.
    task automatic stream_check(input int k, input int n, input string tag,
                                input logic [31:0] e_dout, input logic [31:0] e_act,
                                input logic [31:0] e_rdy, input logic [31:0] e_done);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_dout%0d", tag, i), {31'd0, dout_w[k]},  {31'd0, e_dout[i]});
            chk($sformatf("%s_act%0d",  tag, i), {31'd0, act_w[k]},   {31'd0, e_act[i]});
            chk($sformatf("%s_rdy%0d",  tag, i), {31'd0, ready_w[k]}, {31'd0, e_rdy[i]});
            chk($sformatf("%s_done%0d", tag, i), {31'd0, done_w[k]},  {31'd0, e_done[i]});
            tick();
            if (i == 0) valid_w[k] = 1'b0;
        end
        $display("stream %s: %0d cycles sampled on instance %0d", tag, n, k);
    endtask

    initial begin
        rst     = 1'b1;
        valid_w = '0;
        for (int k = 0; k < 3; k++) din_w[k] = 8'h00;

        // Reset state
        #12;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_dout%0d", k), {31'd0, dout_w[k]},  32'd0);
            chk($sformatf("rst_act%0d",  k), {31'd0, act_w[k]},   32'd0);
            chk($sformatf("rst_done%0d", k), {31'd0, done_w[k]},  32'd0);
            chk($sformatf("rst_rdy%0d",  k), {31'd0, ready_w[k]}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        for (int k = 0; k < 3; k++)
            chk($sformatf("post_rst_rdy%0d", k), {31'd0, ready_w[k]}, 32'd1);
        $display("reset: released");

        // Single word 0xB6, MSB first
        din_w[0] = 8'hB6; valid_w[0] = 1'b1;
        tick();
        valid_w[0] = 1'b0;
        chk("single_rdy_full", {31'd0, ready_w[0]}, 32'd0);
        chk("single_act_wait", {31'd0, act_w[0]},   32'd0);
        tick();
        stream_check(0, 8, "single", 32'h6D, 32'hFF, 32'hFF, 32'h80);
        chk("single_idle_act",  {31'd0, act_w[0]},  32'd0);
        chk("single_idle_dout", {31'd0, dout_w[0]}, 32'd0);
        tick();

        // Back-to-back 0xFF, 0x81
        din_w[0] = 8'hFF; valid_w[0] = 1'b1;
        tick();
        din_w[0] = 8'h81;
        chk("b2b_rdy_full", {31'd0, ready_w[0]}, 32'd0);
        tick();
        stream_check(0, 16, "b2b", 32'h81FF, 32'hFFFF, 32'hFF01, 32'h8080);
        chk("b2b_idle_act", {31'd0, act_w[0]}, 32'd0);
        tick();

        // GAP=2 with 0x03, 0xC0
        din_w[1] = 8'h03; valid_w[1] = 1'b1;
        tick();
        din_w[1] = 8'hC0;
        tick();
        stream_check(1, 18, "gap", 32'h00CC0, 32'h3FCFF, 32'h3FC01, 32'h20080);
        chk("gap_tail_act",  {31'd0, act_w[1]},  32'd0);
        chk("gap_tail_dout", {31'd0, dout_w[1]}, 32'd0);
        tick();
        tick();

        // LSB first, 0x01
        din_w[2] = 8'h01; valid_w[2] = 1'b1;
        tick();
        valid_w[2] = 1'b0;
        tick();
        stream_check(2, 8, "lsb", 32'h01, 32'hFF, 32'hFF, 32'h80);
        chk("lsb_idle_act", {31'd0, act_w[2]}, 32'd0);

        // Backpressure: 0xAA held valid while the buffer is occupied by 0x0F
        din_w[0] = 8'h0F; valid_w[0] = 1'b1;
        tick();
        din_w[0] = 8'hAA;
        chk("bp_rdy_full", {31'd0, ready_w[0]}, 32'd0);
        tick();
        stream_check(0, 16, "bp", 32'h55F0, 32'hFFFF, 32'hFF01, 32'h8080);
        chk("bp_idle_act", {31'd0, act_w[0]}, 32'd0);
        tick();

        // Abort: reset during bit 3 of 0xFF with 0xAA buffered
        din_w[0] = 8'hFF; valid_w[0] = 1'b1;
        tick();
        din_w[0] = 8'hAA;
        tick();
        tick();
        valid_w[0] = 1'b0;
        tick();
        tick();
        chk("abort_pre_dout", {31'd0, dout_w[0]}, 32'd1);
        chk("abort_pre_act",  {31'd0, act_w[0]},  32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_dout", {31'd0, dout_w[0]},  32'd0);
        chk("abort_act",  {31'd0, act_w[0]},   32'd0);
        chk("abort_done", {31'd0, done_w[0]},  32'd0);
        chk("abort_rdy",  {31'd0, ready_w[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("abort_after_dout%0d", i), {31'd0, dout_w[0]},  32'd0);
            chk($sformatf("abort_after_act%0d",  i), {31'd0, act_w[0]},   32'd0);
            chk($sformatf("abort_after_rdy%0d",  i), {31'd0, ready_w[0]}, 32'd1);
        end
        $display("abort: 12 idle cycles sampled after reset release");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
